// File: rtl/apb_responder.sv
// apb_responder: APB completer backed by a 2**ADDR_W x DATA_W register file.
// Supports zero or more wait states, back-to-back transfers, and abandoned
// transfers (psel dropped before pready). Read data and pready are
// combinational from the live bus and the stored state.
module apb_responder #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              pclk,
  input  logic              prstn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic [DATA_W-1:0] prdata
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_STATES);

  // state_q records the bus phase seen in the previous cycle: SETUP means the
  // current cycle is the first ACCESS cycle, ACCESS means a wait state is in
  // progress. A completed or abandoned access returns to IDLE, from which a
  // back-to-back SETUP is picked up directly, so no dead cycle is inserted.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic                acc;
  logic                in_xfer;
  logic                wr_en;
  logic                rd_en;

  // Handshake and read data from the live bus qualifier and stored state.
  always_comb begin
    acc     = psel & penable;
    in_xfer = (state_q == SETUP) || (state_q == ACCESS);
    pready  = acc & in_xfer & (cnt_q == WAIT_CNT);
    wr_en   = pready & pwrite;
    rd_en   = pready & ~pwrite;
    prdata  = rd_en ? mem_q[paddr] : '0;
  end

  // Next-state and wait counter: count only while an access is stalled.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) state_d = SETUP;
      end
      SETUP, ACCESS: begin
        if (pready) begin
          state_d = IDLE;
        end else if (acc) begin
          state_d = ACCESS;
          cnt_d   = cnt_q + 1'b1;
        end else if (psel && !penable) begin
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register-file update: one write at the completing edge of a write access.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[paddr] = pwdata;
  end

  // State, counter and storage registers with asynchronous clear.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_apb_responder.sv
// Directed bench for apb_responder: one zero-wait instance and one
// two-wait-state instance share the bus; psel selects which one responds.
module tb_apb_responder;

  logic       pclk = 1'b0;
  logic       prstn;
  logic       psel0, psel2, penable, pwrite;
  logic [3:0] paddr;
  logic [7:0] pwdata;
  logic       pready0, pready2;
  logic [7:0] prdata0, prdata2;

  int vectors = 0;
  int miscompares = 0;

  always #5 pclk = ~pclk;

  apb_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_STATES(0)) dut0 (
    .pclk(pclk), .prstn(prstn), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready0), .prdata(prdata0)
  );

  apb_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_STATES(2)) dut2 (
    .pclk(pclk), .prstn(prstn), .psel(psel2), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready2), .prdata(prdata2)
  );

  task automatic setup_phase(input bit use2, input bit wr, input logic [3:0] a,
                             input logic [7:0] d);
    @(posedge pclk); #1;
    psel0 = ~use2; psel2 = use2; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d;
  endtask

  task automatic next_cycle();
    @(posedge pclk); #1;
    penable = 1'b1;
  endtask

  task automatic idle_phase();
    @(posedge pclk); #1;
    psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    prstn = 1'b0; psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = 4'd0; pwdata = 8'h00;
    repeat (2) @(posedge pclk);
    #1; psel0 = 1'b1; psel2 = 1'b1; penable = 1'b1; pwrite = 1'b0;
    @(negedge pclk);
    vectors++; if (pready0 !== 1'b0) begin miscompares++; $display("FAIL rst_pready0 got=%b exp=0", pready0); end
    vectors++; if (pready2 !== 1'b0) begin miscompares++; $display("FAIL rst_pready2 got=%b exp=0", pready2); end
    vectors++; if (prdata0 !== 8'h00) begin miscompares++; $display("FAIL rst_prdata0 got=%h exp=00", prdata0); end
    psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
    @(negedge pclk);
    prstn = 1'b1;
  endtask

  task automatic test_reads_after_reset();
    logic [3:0] a [2] = '{4'd0, 4'd15};
    for (int i = 0; i < 2; i++) begin
      setup_phase(1'b0, 1'b0, a[i], 8'h00);
      @(negedge pclk);
      vectors++; if (pready0 !== 1'b0 || prdata0 !== 8'h00) begin miscompares++; $display("FAIL rd0_setup addr=%0d got=%b/%h exp=0/00", a[i], pready0, prdata0); end
      next_cycle();
      @(negedge pclk);
      vectors++; if (pready0 !== 1'b1 || prdata0 !== 8'h00) begin miscompares++; $display("FAIL rd0_access addr=%0d got=%b/%h exp=1/00", a[i], pready0, prdata0); end
      idle_phase();
      @(negedge pclk);
      vectors++; if (pready0 !== 1'b0 || prdata0 !== 8'h00) begin miscompares++; $display("FAIL rd0_idle got=%b/%h exp=0/00", pready0, prdata0); end
    end
  endtask

  task automatic test_writes();
    logic [3:0] a [3] = '{4'd3, 4'd7, 4'd9};
    logic [7:0] d [3] = '{8'hA5, 8'h3C, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      setup_phase(1'b0, 1'b1, a[i], d[i]);
      @(negedge pclk);
      vectors++; if (pready0 !== 1'b0) begin miscompares++; $display("FAIL wr_setup addr=%0d got=%b exp=0", a[i], pready0); end
      next_cycle();
      @(negedge pclk);
      vectors++; if (pready0 !== 1'b1) begin miscompares++; $display("FAIL wr_access addr=%0d got=%b exp=1", a[i], pready0); end
    end
    idle_phase();
    for (int i = 0; i < 3; i++) begin
      setup_phase(1'b0, 1'b0, a[i], 8'h00);
      next_cycle();
      @(negedge pclk);
      vectors++; if (pready0 !== 1'b1 || prdata0 !== d[i]) begin miscompares++; $display("FAIL rd_back addr=%0d got=%b/%h exp=1/%h", a[i], pready0, prdata0, d[i]); end
    end
    idle_phase();
  endtask

  task automatic test_overwrite();
    logic [7:0] d [2] = '{8'h11, 8'h22};
    logic [3:0] ra [2] = '{4'd15, 4'd14};
    logic [7:0] rd [2] = '{8'h22, 8'h00};
    for (int i = 0; i < 2; i++) begin
      setup_phase(1'b0, 1'b1, 4'd15, d[i]);
      next_cycle();
    end
    idle_phase();
    for (int i = 0; i < 2; i++) begin
      setup_phase(1'b0, 1'b0, ra[i], 8'h00);
      next_cycle();
      @(negedge pclk);
      vectors++; if (pready0 !== 1'b1 || prdata0 !== rd[i]) begin miscompares++; $display("FAIL ovw_rd addr=%0d got=%b/%h exp=1/%h", ra[i], pready0, prdata0, rd[i]); end
    end
    idle_phase();
  endtask

  task automatic test_wait_states();
    logic exp_rdy;
    setup_phase(1'b1, 1'b1, 4'd4, 8'h5A);
    @(negedge pclk);
    vectors++; if (pready2 !== 1'b0) begin miscompares++; $display("FAIL ws_wr_setup got=%b exp=0", pready2); end
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) next_cycle();
      @(negedge pclk);
      exp_rdy = (k == 2);
      vectors++; if (pready2 !== exp_rdy) begin miscompares++; $display("FAIL ws_wr_cycle%0d got=%b exp=%b", k, pready2, exp_rdy); end
    end
    idle_phase();
    setup_phase(1'b1, 1'b0, 4'd4, 8'h00);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) next_cycle();
      @(negedge pclk);
      exp_rdy = (k == 2);
      vectors++; if (pready2 !== exp_rdy || prdata2 !== (exp_rdy ? 8'h5A : 8'h00)) begin miscompares++; $display("FAIL ws_rd_cycle%0d got=%b/%h exp=%b/%h", k, pready2, prdata2, exp_rdy, exp_rdy ? 8'h5A : 8'h00); end
    end
    idle_phase();
    // the zero-wait instance was not selected and must still hold 0 at addr 4
    setup_phase(1'b0, 1'b0, 4'd4, 8'h00);
    next_cycle();
    @(negedge pclk);
    vectors++; if (pready0 !== 1'b1 || prdata0 !== 8'h00) begin miscompares++; $display("FAIL ws_other_dut got=%b/%h exp=1/00", pready0, prdata0); end
    idle_phase();
  endtask

  task automatic test_reset_mid();
    logic [3:0] ra [2] = '{4'd2, 4'd4};
    setup_phase(1'b1, 1'b1, 4'd2, 8'h77);
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge pclk);
    vectors++; if (pready2 !== 1'b1) begin miscompares++; $display("FAIL rm_before got=%b exp=1", pready2); end
    #1 prstn = 1'b0;
    #1;
    vectors++; if (pready2 !== 1'b0) begin miscompares++; $display("FAIL rm_drop got=%b exp=0", pready2); end
    idle_phase();
    @(negedge pclk);
    prstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      setup_phase(1'b1, 1'b0, ra[i], 8'h00);
      next_cycle();
      next_cycle();
      next_cycle();
      @(negedge pclk);
      vectors++; if (pready2 !== 1'b1 || prdata2 !== 8'h00) begin miscompares++; $display("FAIL rm_rd addr=%0d got=%b/%h exp=1/00", ra[i], pready2, prdata2); end
    end
    idle_phase();
  endtask

  task automatic test_back_to_back();
    setup_phase(1'b0, 1'b1, 4'd1, 8'h81);
    next_cycle();
    @(negedge pclk);
    vectors++; if (pready0 !== 1'b1) begin miscompares++; $display("FAIL b2b_wr got=%b exp=1", pready0); end
    setup_phase(1'b0, 1'b0, 4'd1, 8'h00);
    @(negedge pclk);
    vectors++; if (pready0 !== 1'b0 || prdata0 !== 8'h00) begin miscompares++; $display("FAIL b2b_setup got=%b/%h exp=0/00", pready0, prdata0); end
    next_cycle();
    @(negedge pclk);
    vectors++; if (pready0 !== 1'b1 || prdata0 !== 8'h81) begin miscompares++; $display("FAIL b2b_rd got=%b/%h exp=1/81", pready0, prdata0); end
    idle_phase();
  endtask

  task automatic test_penable_only();
    @(posedge pclk); #1;
    psel0 = 1'b0; psel2 = 1'b0; penable = 1'b1;
    pwrite = 1'b1; paddr = 4'd1; pwdata = 8'hEE;
    for (int k = 0; k < 4; k++) begin
      @(negedge pclk);
      vectors++; if (pready0 !== 1'b0 || pready2 !== 1'b0 || prdata0 !== 8'h00) begin miscompares++; $display("FAIL pen_only cycle%0d got=%b/%b/%h exp=0/0/00", k, pready0, pready2, prdata0); end
    end
    idle_phase();
    setup_phase(1'b0, 1'b0, 4'd1, 8'h00);
    next_cycle();
    @(negedge pclk);
    vectors++; if (pready0 !== 1'b1 || prdata0 !== 8'h81) begin miscompares++; $display("FAIL pen_only_rd got=%b/%h exp=1/81", pready0, prdata0); end
    idle_phase();
  endtask

  initial begin
    test_reset();
    test_reads_after_reset();
    test_writes();
    test_overwrite();
    test_wait_states();
    test_reset_mid();
    test_back_to_back();
    test_penable_only();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_responder.md
Name: apb_responder

Overview:
- APB (v3-style) completer with a 16-entry x 8-bit register file, addressed by a 4-bit paddr.
- Accepts standard two-phase APB transfers (SETUP then ACCESS) from a single requester.
- Performs single-beat writes and reads, with a configurable number of wait states.
- Sits on a peripheral APB segment as a simple scratch/register target.

Parameters:
- ADDR_W, 4, address width; depth is 2**ADDR_W entries (16).
- DATA_W, 8, data width of pwdata, prdata and each entry.
- WAIT_STATES, 0, number of ACCESS cycles with pready low before pready rises (0..15).

Ports:
- pclk  input  1  APB clock; all state updates on rising edge.
- prstn  input  1  asynchronous active-low reset.
- psel  input  1  completer select.
- penable  input  1  second/subsequent-cycle (ACCESS) indicator.
- pwrite  input  1  1 = write, 0 = read; sampled during the transfer.
- paddr  input  ADDR_W  entry index.
- pwdata  input  DATA_W  write data.
- pready  output  DATA-independent 1  transfer-complete handshake.
- prdata  output  DATA_W  read data.

Behaviour:
- Reset (prstn low, asynchronous assert, synchronous-to-pclk release):
  - all 16 entries clear to 0x00;
  - wait counter clears to 0;
  - FSM goes to IDLE;
  - pready=0, prdata=0x00.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: psel=1 & penable=0 -> SETUP; otherwise stay.
  - SETUP: next cycle -> ACCESS unconditionally; counter cleared.
  - ACCESS: while pready=0, stay and increment counter.
  - ACCESS exit when pready=1 at a clock edge: psel=1 & penable=0 -> SETUP (back-to-back); else -> IDLE.
- Phase qualification: the FSM tracks the phase, but pready/prdata use the live bus qualifier acc = psel & penable.
  - penable=1 with psel=0 is ignored.
- pready:
  - combinational: pready = acc & (counter == WAIT_STATES);
  - WAIT_STATES=0 gives pready=1 in the first ACCESS cycle (zero-wait);
  - pready=0 in IDLE, SETUP and reset.
- Write: at the rising pclk where acc & pwrite & pready = 1, mem[paddr] <= pwdata.
  - Exactly one write per transfer.
  - No effect if reset is active.
- Read: prdata = mem[paddr] when acc & !pwrite & pready; otherwise prdata = 0x00.
  - Combinational from storage.
  - Shows the value stored before any write in the same cycle.
- Address range:
  - all 16 addresses are valid; no decode error, no wrap logic needed;
  - paddr values are taken modulo width (4 bits).
- Inputs paddr/pwrite/pwdata are held stable by the requester from SETUP through completion; no internal capture is required.
- Reset mid-transfer: transfer is aborted, no write occurs, pready drops immediately, FSM returns to IDLE.
- psel deasserted mid-ACCESS before pready: transfer abandoned, no write, -> IDLE, counter cleared.
- Back-to-back transfers: consecutive SETUP/ACCESS pairs without an IDLE cycle are supported with no dead cycle.

Test Plan:
- Reset then writes: write 0xA5->addr 3, 0x3C->addr 7, 0xFF->addr 9 (WAIT_STATES=0).
  - pready=1 in each ACCESS cycle.
  - Read addr 3/7/9 returns 0xA5/0x3C/0xFF with pready=1.
- Reads after reset: read addr 0 and addr 15 without prior write -> prdata=0x00, pready=1.
  - prdata=0x00 and pready=0 in IDLE/SETUP.
- Overwrite and boundary:
  - write 0x11 then 0x22 to addr 15; read addr 15 -> 0x22;
  - addr 14 remains 0x00.
- WAIT_STATES=2: write 0x5A to addr 4.
  - pready low for 2 ACCESS cycles, high in the 3rd; exactly one write.
  - Read addr 4 -> 0x5A after the same stretch.
- Reset mid-operation: assert prstn=0 during an ACCESS write of 0x77 to addr 2 (WAIT_STATES=2).
  - pready=0 immediately; after release, read addr 2 -> 0x00.
- Back-to-back and idle: write addr 1=0x81 immediately followed by read addr 1 with no idle cycle -> 0x81.
  - Then psel=0, penable=1 for several cycles -> pready stays 0, no state change.
